// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a single sign-fixup cycle.
module muldiv_unit #(
   parameter int DATA_W = 32
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [1:0]        Op,
   input  logic [DATA_W-1:0] OperandA,
   input  logic [DATA_W-1:0] OperandB,
   input  logic              MtHi,
   input  logic              MtLo,
   output logic [DATA_W-1:0] Hi,
   output logic [DATA_W-1:0] Lo,
   output logic              Busy,
   output logic              Done,
   output logic              DivByZero
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10} state_t;

   state_t                state_r, nextState_s;
   logic [CNT_W-1:0]      count_r;
   logic [1:0]            op_r;
   logic [2*DATA_W-1:0]   accum_r, stepAccum_s;
   logic [DATA_W-1:0]     opB_r, aRaw_r;
   logic                  negQ_r, negR_r, divZero_r;
   logic [DATA_W-1:0]     hi_r, lo_r, fixHi_s, fixLo_s;
   logic                  busy_r, done_r, dbz_r;
   logic [DATA_W:0]       mulSum_s, addend_s, divShift_s, divDiff_s;
   logic [2*DATA_W-1:0]   product_s;
   logic [DATA_W-1:0]     quot_s, rem_s;

   function automatic logic [DATA_W-1:0] absVal(input logic [DATA_W-1:0] v, input logic signedOp);
      if (signedOp && v[DATA_W-1]) begin
         return {DATA_W{1'b0}} - v;
      end else begin
         return v;
      end
   endfunction

   function automatic logic [DATA_W-1:0] negIf(input logic [DATA_W-1:0] v, input logic neg);
      if (neg) begin
         return {DATA_W{1'b0}} - v;
      end else begin
         return v;
      end
   endfunction

   // State register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Next-state decode
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         IDLE: begin
            if (Start) begin
               nextState_s = CALC;
            end else begin
               nextState_s = IDLE;
            end
         end
         CALC: begin
            if (count_r == CNT_W'(DATA_W - 1)) begin
               nextState_s = FIX;
            end else begin
               nextState_s = CALC;
            end
         end
         FIX:     nextState_s = IDLE;
         default: nextState_s = IDLE;
      endcase
   end

   // One iteration: multiplier/quotient bits live in the low half of accum_r
   always_comb begin
      addend_s   = {(DATA_W+1){1'b0}};
      if (accum_r[0]) begin
         addend_s = {1'b0, opB_r};
      end else begin
         addend_s = {(DATA_W+1){1'b0}};
      end
      mulSum_s   = {1'b0, accum_r[2*DATA_W-1:DATA_W]} + addend_s;
      divShift_s = {accum_r[2*DATA_W-1:DATA_W], accum_r[DATA_W-1]};
      divDiff_s  = divShift_s - {1'b0, opB_r};
      stepAccum_s = accum_r;
      if (!op_r[1]) begin
         stepAccum_s = {mulSum_s, accum_r[DATA_W-1:1]};
      end else if (divDiff_s[DATA_W]) begin
         stepAccum_s = {divShift_s[DATA_W-1:0], accum_r[DATA_W-2:0], 1'b0};
      end else begin
         stepAccum_s = {divDiff_s[DATA_W-1:0], accum_r[DATA_W-2:0], 1'b1};
      end
   end

   // Sign fixup; a zero divisor reports the raw dividend and an all-ones quotient
   always_comb begin
      product_s = accum_r;
      if (negQ_r) begin
         product_s = {(2*DATA_W){1'b0}} - accum_r;
      end else begin
         product_s = accum_r;
      end
      quot_s  = negIf(accum_r[DATA_W-1:0], negQ_r);
      rem_s   = negIf(accum_r[2*DATA_W-1:DATA_W], negR_r);
      fixHi_s = product_s[2*DATA_W-1:DATA_W];
      fixLo_s = product_s[DATA_W-1:0];
      if (!op_r[1]) begin
         fixHi_s = product_s[2*DATA_W-1:DATA_W];
         fixLo_s = product_s[DATA_W-1:0];
      end else if (divZero_r) begin
         fixHi_s = aRaw_r;
         fixLo_s = {DATA_W{1'b1}};
      end else begin
         fixHi_s = rem_s;
         fixLo_s = quot_s;
      end
   end

   // Datapath, HI/LO and registered status outputs
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         count_r   <= {CNT_W{1'b0}};
         op_r      <= 2'b00;
         accum_r   <= {(2*DATA_W){1'b0}};
         opB_r     <= {DATA_W{1'b0}};
         aRaw_r    <= {DATA_W{1'b0}};
         negQ_r    <= 1'b0;
         negR_r    <= 1'b0;
         divZero_r <= 1'b0;
         hi_r      <= {DATA_W{1'b0}};
         lo_r      <= {DATA_W{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         dbz_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               dbz_r  <= 1'b0;
               if (Start) begin
                  op_r      <= Op;
                  accum_r   <= {{DATA_W{1'b0}}, absVal(OperandA, ~Op[0])};
                  opB_r     <= absVal(OperandB, ~Op[0]);
                  aRaw_r    <= OperandA;
                  negQ_r    <= ~Op[0] & (OperandA[DATA_W-1] ^ OperandB[DATA_W-1]);
                  negR_r    <= ~Op[0] & OperandA[DATA_W-1];
                  divZero_r <= Op[1] & (OperandB == {DATA_W{1'b0}});
                  count_r   <= {CNT_W{1'b0}};
                  busy_r    <= 1'b1;
               end else begin
                  if (MtHi) hi_r <= OperandA;
                  if (MtLo) lo_r <= OperandA;
               end
            end
            CALC: begin
               accum_r <= stepAccum_s;
               count_r <= count_r + CNT_W'(1);
            end
            FIX: begin
               hi_r   <= fixHi_s;
               lo_r   <= fixLo_s;
               done_r <= 1'b1;
               dbz_r  <= divZero_r;
               busy_r <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               dbz_r  <= 1'b0;
            end
         endcase
      end
   end

   assign Hi        = hi_r;
   assign Lo        = lo_r;
   assign Busy      = busy_r;
   assign Done      = done_r;
   assign DivByZero = dbz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected HI/LO/DivByZero and
// completion cycle; a monitor pops and compares on every Done pulse.
module tb_muldiv_unit;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic [31:0] OperandA = 32'h0;
   logic [31:0] OperandB = 32'h0;
   logic        MtHi = 1'b0;
   logic        MtLo = 1'b0;
   logic [31:0] Hi, Lo;
   logic        Busy, Done, DivByZero;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          cyc;
   } exp_t;

   exp_t sbQ[$];
   exp_t popped;
   int   vectors = 0;
   int   miscompares = 0;
   int   cycleCount = 0;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   muldiv_unit #(.DATA_W(32)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
      .OperandA(OperandA), .OperandB(OperandB), .MtHi(MtHi), .MtLo(MtLo),
      .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cycleCount <= cycleCount + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every Done pulse must match the oldest outstanding expectation
   always @(negedge Clock) begin
      if (Done) begin
         if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: Done=1 with no op outstanding (t=%0t)", $time);
         end else begin
            popped = sbQ.pop_front();
            check("hi", Hi, popped.hi);
            check("lo", Lo, popped.lo);
            check("div_by_zero", {31'b0, DivByZero}, {31'b0, popped.dbz});
            check("done_cycle", cycleCount, popped.cyc);
         end
      end
   end

   // Caller is positioned at a negedge; drives one Start cycle and records the expectation
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expHi, input logic [31:0] expLo,
                        input logic expDbz, input logic withMtLo);
      exp_t e;
      Start = 1'b1; Op = op; OperandA = a; OperandB = b; MtLo = withMtLo;
      @(posedge Clock);
      #1;
      Start = 1'b0; MtLo = 1'b0;
      OperandA = 32'hDEADBEEF; OperandB = 32'h0BADF00D;
      e.hi = expHi; e.lo = expLo; e.dbz = expDbz; e.cyc = cycleCount + 33;
      sbQ.push_back(e);
      check("busy_after_start", {31'b0, Busy}, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sbQ.size() != 0 && n < 200) begin
         @(negedge Clock);
         n++;
      end
      if (sbQ.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d ops outstanding, expected 0", sbQ.size());
         sbQ.delete();
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge Clock);
      check("reset_hi", Hi, 32'h0);
      check("reset_lo", Lo, 32'h0);
      check("reset_busy", {31'b0, Busy}, 32'd0);
      check("reset_done", {31'b0, Done}, 32'd0);
      check("reset_dbz", {31'b0, DivByZero}, 32'd0);
      Reset = 1'b0;

      // MTHI/MTLO together, then MTHI alone
      @(negedge Clock);
      MtHi = 1'b1; MtLo = 1'b1; OperandA = 32'h0F0F0F0F;
      @(posedge Clock); #1;
      MtHi = 1'b0; MtLo = 1'b0;
      check("mt_both_hi", Hi, 32'h0F0F0F0F);
      check("mt_both_lo", Lo, 32'h0F0F0F0F);
      @(negedge Clock);
      MtHi = 1'b1; OperandA = 32'hAAAA0000;
      @(posedge Clock); #1;
      MtHi = 1'b0;
      check("mthi_hi", Hi, 32'hAAAA0000);
      check("mthi_lo_kept", Lo, 32'h0F0F0F0F);

      // Reset in the middle of CALC discards the op
      @(negedge Clock);
      Start = 1'b1; Op = MULT; OperandA = 32'd5; OperandB = 32'd6;
      @(posedge Clock); #1;
      Start = 1'b0;
      repeat (10) @(negedge Clock);
      check("midcalc_busy", {31'b0, Busy}, 32'd1);
      check("midcalc_hi_held", Hi, 32'hAAAA0000);
      Reset = 1'b1;
      #1;
      check("async_reset_hi", Hi, 32'h0);
      check("async_reset_lo", Lo, 32'h0);
      check("async_reset_busy", {31'b0, Busy}, 32'd0);
      @(negedge Clock);
      Reset = 1'b0;

      // Multiply
      @(negedge Clock); issue(MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0); drain();
      @(negedge Clock); issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0); drain();
      @(negedge Clock); issue(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0); drain();

      // Divide, truncating toward zero
      @(negedge Clock); issue(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0); drain();
      @(negedge Clock); issue(DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0); drain();

      // Start with MtLo: Start wins; then Start/MtLo while Busy are ignored
      @(negedge Clock); issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
      check("start_beats_mtlo", Lo, 32'hFFFFFFFD);
      repeat (4) @(negedge Clock);
      Start = 1'b1; Op = MULTU; MtLo = 1'b1; OperandA = 32'h00005555; OperandB = 32'd3;
      @(posedge Clock); #1;
      Start = 1'b0; MtLo = 1'b0;
      check("mtlo_busy_ignored", Lo, 32'hFFFFFFFD);
      check("start_busy_ignored", {31'b0, Busy}, 32'd1);
      drain();

      // Division by zero and signed overflow
      @(negedge Clock); issue(DIVU, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1'b0); drain();
      @(negedge Clock); issue(DIV,  32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1'b0); drain();
      @(negedge Clock); issue(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0); drain();

      // Back-to-back: second Start in the Done cycle
      @(negedge Clock); issue(MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b0);
      begin
         int n = 0;
         do begin
            @(negedge Clock);
            n++;
         end while (!Done && n < 60);
         check("b2b_done_seen", {31'b0, Done}, 32'd1);
      end
      issue(DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b0);
      drain();

      repeat (3) @(negedge Clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, directly downstream of the register file.
- Consumes register-file ReadData1/ReadData2 as OperandA/OperandB and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Holds the 64-bit result in Hi/Lo for MFHI/MFLO and accepts MTHI/MTLO writes.
- Busy is the pipeline's stall source for dependent HI/LO accesses.

Parameters:
- DATA_W, 32, operand/Hi/Lo width; the iteration count equals DATA_W.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high; clears all state.
- Start  input  1  launch operation; sampled only in IDLE.
- Op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- OperandA  input  DATA_W  rs value, from register-file ReadData1; multiplicand or dividend.
- OperandB  input  DATA_W  rt value, from register-file ReadData2; multiplier or divisor.
- MtHi  input  1  write OperandA into Hi (MTHI).
- MtLo  input  1  write OperandA into Lo (MTLO).
- Hi  output  DATA_W  HI register: product upper half, or remainder.
- Lo  output  DATA_W  LO register: product lower half, or quotient.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse when Hi/Lo receive a result.
- DivByZero  output  1  one-cycle pulse with Done for DIV/DIVU with OperandB = 0.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0.
  - State returns to IDLE and the iteration counter is cleared.
  - A partial result is discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - If Start=1 at edge N: latch Op and the operand magnitudes (absolute values for signed ops, with result-sign flags recorded). Counter=0, go to CALC, Busy=1.
  - Start has priority over MtHi/MtLo in the same cycle; the Mt writes are dropped.
  - Otherwise MtHi/MtLo load OperandA into Hi/Lo at the edge; both may be asserted together.
- CALC: one iteration per cycle for DATA_W cycles (counter 0..DATA_W-1). At counter=DATA_W-1, go to FIX.
  - Multiply: shift-add on a 2*DATA_W accumulator.
  - Divide: restoring shift-subtract, producing a DATA_W-bit quotient and remainder.
- FIX (1 cycle):
  - Apply sign correction: negate the product if the operand signs differ; quotient sign = sign(A) xor sign(B); remainder takes the sign of the dividend (truncation toward zero).
  - Write Hi/Lo, set Done=1, Busy=0, return to IDLE.
- Latency: Start sampled at edge N -> Hi/Lo updated, Done=1 and Busy=0 after edge N+DATA_W+1 (N+33 for DATA_W=32). Done is high for exactly one cycle.
- Start, MtHi and MtLo are ignored while Busy=1. Hi/Lo hold their previous values until FIX.
- Start may be asserted in the cycle Done is high (state is IDLE); a back-to-back op begins at that edge.
- Division by zero (DIV or DIVU): Lo=all ones, Hi=OperandA as latched at Start, DivByZero=1 with Done. Runs the full latency.
- Signed overflow, DIV of 0x80000000 by 0xFFFFFFFF: Lo=0x80000000, Hi=0, no DivByZero.
- MULTU/DIVU treat operands as unsigned. The full 2*DATA_W product is kept; no truncation or saturation.
- Operand inputs are needed only in the Start cycle; they are not sampled afterwards.

Test Plan:
- Reset mid-CALC (10 cycles after a MULT Start) -> Hi=0, Lo=0, Busy=0 immediately; the next op runs normally.
- MULT A=0xFFFFFFFD (-3), B=7 -> after 33 cycles Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, Done pulses once. MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIVU A=100, B=7 -> Lo=14, Hi=2.
- DIVU A=0x1234, B=0 -> Lo=0xFFFFFFFF, Hi=0x1234, DivByZero=1 with Done. DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MtHi with A=0xAAAA0000 in IDLE -> Hi=0xAAAA0000 next cycle. MtLo during Busy -> ignored. Start with MtLo in IDLE -> Start wins, MtLo dropped.
- Start re-asserted while Busy -> ignored, no change in Busy or counter. Start in the Done cycle -> second op completes exactly 33 cycles later.
